// File: rtl/data_source_sched_pkg.sv
// -----------------------------------------------------------------------------
// data_source_sched_pkg
// Shared types and helpers for the data-source sequencer.
//   state_t : sequencer states (IDLE, RUN, DRAIN)
//   PASS_W  : width of the pass-count control
//   ch_lsb  : bit offset of a channel's sample inside the packed source bus
// -----------------------------------------------------------------------------
package data_source_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int PASS_W = 8;

   // Channel k occupies bits [k*width +: width] of the packed sample bus.
   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage

// File: rtl/data_source_sched_pick.sv
// -----------------------------------------------------------------------------
// data_source_sched_pick
// Combinational channel finder over an enable mask.
//   mask    in  NUM_CH : enabled channels
//   cur     in  CH_W   : currently selected channel
//   next_ch out CH_W   : lowest enabled channel strictly above cur
//   found   out 1      : next_ch is valid
//   lowest  out CH_W   : lowest enabled channel (0 when mask is empty)
// -----------------------------------------------------------------------------
module data_source_sched_pick #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur,
   output logic [CH_W-1:0]   next_ch,
   output logic              found,
   output logic [CH_W-1:0]   lowest
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      next_ch = '0;
      found   = 1'b0;
      lowest  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lowest = CH_W'(i);
            if (i > int'(cur)) begin
               next_ch = CH_W'(i);
               found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/data_source_sched.sv
// -----------------------------------------------------------------------------
// data_source_sched
// Sequences per-channel data-source triggers (one channel at a time, ascending
// over the enabled mask, for a programmed number of passes) and funnels the
// selected channel's valid/data onto one registered, channel-tagged stream.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, stop        : start request (IDLE only), abort request
//   burst_len          : trigger-high cycles per channel (latched on start)
//   passes             : pass count, 0 behaves as 1 (latched on start)
//   ch_mask            : enabled channels (latched on start)
//   trigger_out        : one-hot or zero trigger to the sources
//   src_valid/src_data : per-source beats, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_data/out_ch : forwarded beat and its channel
//   busy, done         : not-IDLE flag, one-cycle normal-completion pulse
//   err                : sticky beat-count mismatch flag
//
// Build option: define DATA_SOURCE_SCHED_BEAT_CHECK_EN to count beats per
// burst and raise err on mismatch; otherwise err is tied low.
// -----------------------------------------------------------------------------
module data_source_sched
   import data_source_sched_pkg::*;
#(
   parameter int  NUM_CH     = 4,
   parameter int  DATA_WIDTH = 16,
   parameter int  BURST_W    = 10,
   localparam int CH_W       = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         stop,
   input  logic [BURST_W-1:0]           burst_len,
   input  logic [PASS_W-1:0]            passes,
   input  logic [NUM_CH-1:0]            ch_mask,
   output logic [NUM_CH-1:0]            trigger_out,
   input  logic [NUM_CH-1:0]            src_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] src_data,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]              out_ch,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   state_t              state_reg, state_next;
   logic [NUM_CH-1:0]   mask_reg, mask_next;
   logic [BURST_W-1:0]  len_reg, len_next;
   logic [PASS_W-1:0]   passes_reg, passes_next;
   logic [PASS_W-1:0]   pass_cnt_reg, pass_cnt_next;
   logic [BURST_W-1:0]  burst_cnt_reg, burst_cnt_next;
   logic [CH_W-1:0]     cur_ch_reg, cur_ch_next;
   logic                stop_reg, stop_next;
   logic [NUM_CH-1:0]   trigger_reg, trigger_next;
   logic                done_reg, done_next;
   logic                out_valid_reg;
   logic [DATA_WIDTH-1:0] out_data_reg;
   logic [CH_W-1:0]     out_ch_reg;

   logic                start_ok;
   logic                sel_valid;
   logic [NUM_CH-1:0]   pick_mask;
   logic [CH_W-1:0]     pick_next, pick_lowest;
   logic                pick_found;
   logic [DATA_WIDTH-1:0] src_word [NUM_CH];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign src_word[gi] = src_data[ch_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
   end

   // In IDLE the finder looks at the live mask so the first channel is known
   // on the accepting edge; afterwards it works on the latched mask.
   assign pick_mask = (state_reg == IDLE) ? ch_mask : mask_reg;

   data_source_sched_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_pick (
      .mask    (pick_mask),
      .cur     (cur_ch_reg),
      .next_ch (pick_next),
      .found   (pick_found),
      .lowest  (pick_lowest)
   );

   assign start_ok  = start && !stop && (burst_len != '0) && (ch_mask != '0);
   assign sel_valid = src_valid[cur_ch_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         mask_reg      <= '0;
         len_reg       <= '0;
         passes_reg    <= '0;
         pass_cnt_reg  <= '0;
         burst_cnt_reg <= '0;
         cur_ch_reg    <= '0;
         stop_reg      <= 1'b0;
         trigger_reg   <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mask_reg      <= mask_next;
         len_reg       <= len_next;
         passes_reg    <= passes_next;
         pass_cnt_reg  <= pass_cnt_next;
         burst_cnt_reg <= burst_cnt_next;
         cur_ch_reg    <= cur_ch_next;
         stop_reg      <= stop_next;
         trigger_reg   <= trigger_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      mask_next      = mask_reg;
      len_next       = len_reg;
      passes_next    = passes_reg;
      pass_cnt_next  = pass_cnt_reg;
      burst_cnt_next = burst_cnt_reg;
      cur_ch_next    = cur_ch_reg;
      stop_next      = stop_reg;
      trigger_next   = trigger_reg;
      done_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start_ok) begin
               state_next     = RUN;
               mask_next      = ch_mask;
               len_next       = burst_len;
               passes_next    = (passes == '0) ? PASS_W'(1) : passes;
               pass_cnt_next  = '0;
               cur_ch_next    = pick_lowest;
               burst_cnt_next = BURST_W'(1);
               stop_next      = 1'b0;
               trigger_next   = NUM_CH'(1) << pick_lowest;
            end
         end

         RUN: begin
            // burst_cnt holds the number of trigger-high cycles already issued
            if (stop || (burst_cnt_reg == len_reg)) begin
               state_next   = DRAIN;
               trigger_next = '0;
               stop_next    = stop_reg || stop;
            end else begin
               burst_cnt_next = burst_cnt_reg + BURST_W'(1);
            end
         end

         DRAIN: begin
            stop_next = stop_reg || stop;
            if (!sel_valid) begin
               if (stop_reg || stop) begin
                  state_next = IDLE;
               end else if (pick_found) begin
                  state_next     = RUN;
                  cur_ch_next    = pick_next;
                  burst_cnt_next = BURST_W'(1);
                  trigger_next   = NUM_CH'(1) << pick_next;
               end else if (({1'b0, pass_cnt_reg} + (PASS_W+1)'(1)) < {1'b0, passes_reg}) begin
                  state_next     = RUN;
                  pass_cnt_next  = pass_cnt_reg + PASS_W'(1);
                  cur_ch_next    = pick_lowest;
                  burst_cnt_next = BURST_W'(1);
                  trigger_next   = NUM_CH'(1) << pick_lowest;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end

         default: begin
            state_next   = IDLE;
            trigger_next = '0;
         end
      endcase
   end

   // Output stream: registered copy of the selected channel; data and tag
   // only move on a forwarded beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
      end else begin
         out_valid_reg <= (state_reg != IDLE) && sel_valid;
         if ((state_reg != IDLE) && sel_valid) begin
            out_data_reg <= src_word[cur_ch_reg];
            out_ch_reg   <= cur_ch_reg;
         end
      end
   end

`ifdef DATA_SOURCE_SCHED_BEAT_CHECK_EN
   logic [BURST_W:0] beat_cnt_reg;
   logic             err_reg;
   logic             burst_load;
   logic             drain_exit;

   assign burst_load = (state_next == RUN) && (state_reg != RUN);
   assign drain_exit = (state_reg == DRAIN) && !sel_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         if ((state_reg == IDLE) && (state_next == RUN)) begin
            err_reg <= 1'b0;
         end else if (drain_exit && (beat_cnt_reg != {1'b0, len_reg})) begin
            err_reg <= 1'b1;
         end
         // saturate so a chattering source cannot wrap back to a match
         if (burst_load) begin
            beat_cnt_reg <= '0;
         end else if ((state_reg != IDLE) && sel_valid && !(&beat_cnt_reg)) begin
            beat_cnt_reg <= beat_cnt_reg + (BURST_W+1)'(1);
         end
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   assign trigger_out = trigger_reg;
   assign out_valid   = out_valid_reg;
   assign out_data    = out_data_reg;
   assign out_ch      = out_ch_reg;
   assign busy        = (state_reg != IDLE);
   assign done        = done_reg;

endmodule

// File: tb/tb_data_source_sched.sv
// -----------------------------------------------------------------------------
// tb_data_source_sched
// Randomized bench for data_source_sched. Source models answer triggers with
// registered beats (data = per-run random base + beat index); off-mask
// channels chatter randomly. Expected beat streams and burst lists are built
// from the mask/length/pass rules, independent of the design's state machine.
// Define DATA_SOURCE_SCHED_BEAT_CHECK_EN for both files to cover err.
// -----------------------------------------------------------------------------
module tb_data_source_sched;

   localparam int NUM_CH = 4;
   localparam int DW     = 16;
   localparam int BW     = 10;
   localparam int CH_W   = $clog2(NUM_CH);

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic                   stop = 1'b0;
   logic [BW-1:0]          burst_len = '0;
   logic [7:0]             passes = '0;
   logic [NUM_CH-1:0]      ch_mask = '0;
   logic [NUM_CH-1:0]      trigger_out;
   logic [NUM_CH-1:0]      src_valid = '0;
   logic [NUM_CH*DW-1:0]   src_data = '0;
   logic                   out_valid;
   logic [DW-1:0]          out_data;
   logic [CH_W-1:0]        out_ch;
   logic                   busy;
   logic                   done;
   logic                   err;

   int checks = 0;
   int errors = 0;

   data_source_sched #(
      .NUM_CH     (NUM_CH),
      .DATA_WIDTH (DW),
      .BURST_W    (BW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .burst_len   (burst_len),
      .passes      (passes),
      .ch_mask     (ch_mask),
      .trigger_out (trigger_out),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ch      (out_ch),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- source models ----------------
   logic [NUM_CH-1:0] noise_mask = '0;
   logic [DW-1:0]     base [NUM_CH];
   int unsigned       seq  [NUM_CH] = '{default: 0};
   int                drop_req = 0;
   int                drop_ack = 0;

   always @(posedge clk) begin
      for (int k = 0; k < NUM_CH; k++) begin
         if (trigger_out[k]) begin
            if ((drop_req != drop_ack) && (seq[k] == 1)) begin
               src_valid[k] <= 1'b0;
               drop_ack     <= drop_req;
            end else begin
               src_valid[k] <= 1'b1;
            end
            src_data[k*DW +: DW] <= base[k] + DW'(seq[k]);
            seq[k]               <= seq[k] + 1;
         end else begin
            src_valid[k]         <= noise_mask[k] & 1'($urandom);
            src_data[k*DW +: DW] <= DW'($urandom);
            seq[k]               <= 0;
         end
      end
   end

   // ---------------- monitor ----------------
   logic [CH_W+DW-1:0] got_beats [$];
   int                 burst_chs [$];
   int                 burst_lens [$];
   int                 done_cnt = 0;
   int                 onehot_viol = 0;
   int                 gap_viol = 0;
   logic [NUM_CH-1:0]  prev_trig = '0;
   int                 run_len = 0;
   int                 run_ch = 0;

   function automatic int trig_index(input logic [NUM_CH-1:0] t);
      for (int i = 0; i < NUM_CH; i++) if (t[i]) return i;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (out_valid) got_beats.push_back({out_ch, out_data});
      if (done) done_cnt <= done_cnt + 1;
      if ($countones(trigger_out) > 1) onehot_viol <= onehot_viol + 1;
      if (trigger_out != '0) begin
         if (trigger_out == prev_trig) begin
            run_len <= run_len + 1;
         end else begin
            if (prev_trig != '0) begin
               gap_viol <= gap_viol + 1;
               burst_chs.push_back(run_ch);
               burst_lens.push_back(run_len);
            end
            run_len <= 1;
            run_ch  <= trig_index(trigger_out);
         end
      end else if (prev_trig != '0) begin
         burst_chs.push_back(run_ch);
         burst_lens.push_back(run_len);
      end
      prev_trig <= trigger_out;
   end

   // ---------------- helpers ----------------
   task automatic kick(input logic [NUM_CH-1:0] m, input int l, input int p, input logic with_stop);
      @(negedge clk);
      ch_mask   = m;
      burst_len = BW'(l);
      passes    = 8'(p);
      start     = 1'b1;
      stop      = with_stop;
      @(negedge clk);
      start     = 1'b0;
      stop      = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   function automatic int lowest_ch(input logic [NUM_CH-1:0] m);
      for (int i = 0; i < NUM_CH; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic int highest_ch(input logic [NUM_CH-1:0] m);
      for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) return i;
      return 0;
   endfunction

   // Full run: stimulus, then compare against the pass/channel/beat model.
   task automatic run_check(input logic [NUM_CH-1:0] m, input int l, input int p);
      int b0, br0, d0, ov0, gv0, np, nexp;
      bit ok;
      logic [CH_W+DW-1:0] exp_q [$];
      int exp_ch [$];
      b0 = got_beats.size(); br0 = burst_chs.size();
      d0 = done_cnt; ov0 = onehot_viol; gv0 = gap_viol;
      for (int k = 0; k < NUM_CH; k++) base[k] = DW'($urandom);
      noise_mask = ~m;
      kick(m, l, p, 1'b0);
      chk("first_trigger", 32'(trigger_out), 32'(1 << lowest_ch(m)));
      chk("busy_after_start", 32'(busy), 32'd1);
      @(negedge clk);
      chk("out_valid_t2", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("out_valid_t3", 32'(out_valid), 32'd1);
      wait_idle(ok);
      chk("idle_timeout", 32'(ok), 32'd1);
      repeat (4) @(negedge clk);

      np = (p == 0) ? 1 : p;
      for (int ps = 0; ps < np; ps++)
         for (int ch = 0; ch < NUM_CH; ch++)
            if (m[ch]) begin
               exp_ch.push_back(ch);
               for (int i = 0; i < l; i++)
                  exp_q.push_back({CH_W'(ch), DW'(base[ch] + DW'(i))});
            end

      nexp = exp_q.size();
      chk("beat_count", 32'(got_beats.size() - b0), 32'(nexp));
      for (int j = 0; j < nexp && (b0 + j) < got_beats.size(); j++)
         chk("beat", 32'(got_beats[b0 + j]), 32'(exp_q[j]));
      chk("burst_count", 32'(burst_chs.size() - br0), 32'(exp_ch.size()));
      for (int j = 0; j < exp_ch.size() && (br0 + j) < burst_chs.size(); j++) begin
         chk("burst_ch", 32'(burst_chs[br0 + j]), 32'(exp_ch[j]));
         chk("burst_len", 32'(burst_lens[br0 + j]), 32'(l));
      end
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("err_clean", 32'(err), 32'd0);
      chk("trig_onehot", 32'(onehot_viol - ov0), 32'd0);
      chk("trig_gap", 32'(gap_viol - gv0), 32'd0);
      chk("out_ch_hold", 32'(out_ch), 32'(highest_ch(m)));
      $display("run mask=%b len=%0d passes=%0d beats=%0d/%0d", m, l, p,
               got_beats.size() - b0, nexp);
   endtask

   // Start that must be ignored: nothing may move.
   task automatic ignored_start(input string tag, input logic [NUM_CH-1:0] m, input int l,
                                input logic with_stop);
      int d0;
      d0 = done_cnt;
      kick(m, l, 1, with_stop);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_trig"}, 32'(trigger_out), 32'd0);
      repeat (3) @(negedge clk);
      chk({tag, "_busy_late"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done_cnt - d0), 32'd0);
      $display("ignored start %s mask=%b len=%0d stop=%0b", tag, m, l, with_stop);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      int d0, br0;
      for (int k = 0; k < NUM_CH; k++) base[k] = '0;

      repeat (3) @(negedge clk);
      chk("rst_trig", 32'(trigger_out), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);

      run_check(4'b0101, 3, 1);
      run_check(4'b0010, 2, 3);
      run_check(4'b1111, 1, 0);

      ignored_start("len0", 4'b0101, 0, 1'b0);
      ignored_start("mask0", 4'b0000, 3, 1'b0);
      ignored_start("start_stop", 4'b0001, 3, 1'b1);

      // stop on the second RUN cycle of an 8-cycle burst
      d0 = done_cnt; br0 = burst_chs.size();
      noise_mask = 4'b1001;
      kick(4'b0110, 8, 1, 1'b0);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_trig_drop", 32'(trigger_out), 32'd0);
      chk("stop_busy_drain", 32'(busy), 32'd1);
      wait_idle(ok);
      chk("stop_idle_timeout", 32'(ok), 32'd1);
      repeat (4) @(negedge clk);
      chk("stop_done", 32'(done_cnt - d0), 32'd0);
      chk("stop_bursts", 32'(burst_chs.size() - br0), 32'd1);
      if (burst_chs.size() > br0) chk("stop_burst_len", 32'(burst_lens[br0]), 32'd2);
      $display("stop test done_pulses=%0d", done_cnt - d0);

      // asynchronous reset in the middle of a burst
      noise_mask = 4'b1110;
      kick(4'b0001, 8, 1, 1'b0);
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_trig", 32'(trigger_out), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data", 32'(out_data), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst_no_done", 32'(done_cnt - d0), 32'd0);
      $display("async reset test");
      run_check(4'b1001, 4, 2);

`ifdef DATA_SOURCE_SCHED_BEAT_CHECK_EN
      // one dropped beat must flag err; the next accepted start clears it
      noise_mask = 4'b1110;
      drop_req = drop_req + 1;
      kick(4'b0001, 4, 1, 1'b0);
      wait_idle(ok);
      chk("drop_idle_timeout", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
      chk("drop_err", 32'(err), 32'd1);
      $display("beat drop test err=%0b", err);
      run_check(4'b0011, 3, 1);
`endif

      for (int r = 0; r < 20; r++)
         run_check(4'($urandom_range(1, 15)), $urandom_range(1, 6), $urandom_range(0, 3));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
